// File: rtl/tcp_lb_pkg.sv
// rtl/tcp_lb_pkg.sv - shared types and constants for the TCP loopback responder
//
// Purpose: metaIntf payload layouts, FSM state encoding and common constants
// used by tcp_loopback_responder and its payload FIFO.
package tcp_lb_pkg;

    localparam int         LB_DATA_BITS = 512;
    localparam int         BPB          = LB_DATA_BITS / 8;
    localparam logic [1:0] ERR_SIZE     = 2'b01;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] sid;
    } tcp_tx_meta_t;

    typedef struct packed {
        logic [1:0]  err;
        logic [29:0] space;
        logic [15:0] len;
        logic [15:0] sid;
    } tcp_tx_stat_t;

    typedef struct packed {
        logic        closed;
        logic [15:0] port;
        logic [31:0] ip;
        logic [15:0] len;
        logic [15:0] sid;
    } tcp_notify_t;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] sid;
    } tcp_rd_pkg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STAT,
        ST_DATA_IN,
        ST_NOTIFY,
        ST_WAIT_RD,
        ST_RX_META,
        ST_DATA_OUT
    } lb_state_t;

endpackage

// File: rtl/tcp_lb_fifo.sv
// rtl/tcp_lb_fifo.sv - first-word-fall-through payload FIFO for the loopback responder
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data      push one entry (ignored while full)
//   rd_en, rd_data      pop one entry (ignored while empty); rd_data shows the head
//   full, empty         occupancy flags
//   free_cnt            number of free entries
module tcp_lb_fifo #(
    parameter int WIDTH = 576,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty after wrap.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr == rd_ptr);
    assign free_cnt = (AW+1)'(DEPTH) - count;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/tcp_loopback_responder.sv
// rtl/tcp_loopback_responder.sv - TCP stack stand-in that loops user tx payload back as rx
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   tcp_tx_meta_*        slave  {len, sid} send request
//   tcp_tx_stat_*        master {err, space, len, sid} send status
//   axis_tcp_sink_*      slave  tx payload stream
//   tcp_notify_*         master {closed, port, ip, len, sid} rx notification
//   tcp_rd_pkg_*         slave  {len, sid} read request
//   tcp_rx_meta_*        master {sid} rx header
//   axis_tcp_src_*       master rx payload stream, tid tied to 0
//   err_cnt              saturating protocol-error counter
module tcp_loopback_responder
    import tcp_lb_pkg::*;
#(
    parameter int          DATA_BITS  = LB_DATA_BITS,
    parameter int          FIFO_DEPTH = 64,
    parameter logic [31:0] LOOP_IP    = 32'h0A000001,
    parameter logic [15:0] LOOP_PORT  = 16'd5001
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     tcp_tx_meta_valid,
    output logic                     tcp_tx_meta_ready,
    input  logic [31:0]              tcp_tx_meta_data,
    output logic                     tcp_tx_stat_valid,
    input  logic                     tcp_tx_stat_ready,
    output logic [63:0]              tcp_tx_stat_data,
    input  logic [DATA_BITS-1:0]     axis_tcp_sink_tdata,
    input  logic                     axis_tcp_sink_tlast,
    input  logic                     axis_tcp_sink_tvalid,
    output logic                     axis_tcp_sink_tready,
    output logic                     tcp_notify_valid,
    input  logic                     tcp_notify_ready,
    output logic [80:0]              tcp_notify_data,
    input  logic                     tcp_rd_pkg_valid,
    output logic                     tcp_rd_pkg_ready,
    input  logic [31:0]              tcp_rd_pkg_data,
    output logic                     tcp_rx_meta_valid,
    input  logic                     tcp_rx_meta_ready,
    output logic [15:0]              tcp_rx_meta_data,
    output logic [DATA_BITS-1:0]     axis_tcp_src_tdata,
    output logic [DATA_BITS/8-1:0]   axis_tcp_src_tkeep,
    output logic                     axis_tcp_src_tlast,
    output logic [7:0]               axis_tcp_src_tid,
    output logic                     axis_tcp_src_tvalid,
    input  logic                     axis_tcp_src_tready,
    output logic [15:0]              err_cnt
);

    localparam int          KEEP_BITS = DATA_BITS / 8;
    localparam int          SH        = $clog2(KEEP_BITS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] MAX_LEN   = 32'(FIFO_DEPTH * KEEP_BITS);

    lb_state_t              state;
    tcp_tx_meta_t           meta;
    tcp_rd_pkg_t            rd_req;
    tcp_tx_stat_t           stat_q;
    tcp_notify_t            notify_q;
    logic [15:0]            lat_sid, lat_len, beats, in_cnt, out_cnt;
    logic [16:0]            len_rnd;
    logic [15:0]            beats_n;
    logic                   len_bad, in_last, out_last, rd_match, err_event;
    logic [SH-1:0]          rem;
    logic [KEEP_BITS-1:0]   ones, wr_keep;
    logic                   tx_hs, stat_hs, sink_hs, notify_hs, rd_hs, rx_meta_hs, src_hs;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          free_cnt;
    logic [29:0]            space_bytes;

    assign meta       = tcp_tx_meta_data;
    assign rd_req     = tcp_rd_pkg_data;
    assign tx_hs      = tcp_tx_meta_valid && tcp_tx_meta_ready;
    assign stat_hs    = tcp_tx_stat_valid && tcp_tx_stat_ready;
    assign sink_hs    = axis_tcp_sink_tvalid && axis_tcp_sink_tready;
    assign notify_hs  = tcp_notify_valid && tcp_notify_ready;
    assign rd_hs      = tcp_rd_pkg_valid && tcp_rd_pkg_ready;
    assign rx_meta_hs = tcp_rx_meta_valid && tcp_rx_meta_ready;
    assign src_hs     = axis_tcp_src_tvalid && axis_tcp_src_tready;

    assign len_rnd     = {1'b0, meta.len} + 17'(KEEP_BITS - 1);
    assign beats_n     = 16'(len_rnd >> SH);
    assign len_bad     = (meta.len == 16'd0) || (32'(meta.len) > MAX_LEN);
    assign space_bytes = 30'(free_cnt) * 30'(KEEP_BITS);
    assign in_last     = (in_cnt == beats - 16'd1);
    assign out_last    = (out_cnt == beats - 16'd1);
    assign rd_match    = (rd_req.sid == lat_sid) && (rd_req.len == lat_len);

    // The keep mask is fixed at ingest time so egress only has to replay it.
    assign rem     = lat_len[SH-1:0];
    assign ones    = '1;
    assign wr_keep = (in_last && rem != '0) ? ~(ones << rem) : ones;

    assign axis_tcp_sink_tready = (state == ST_DATA_IN) && !fifo_full;
    assign axis_tcp_src_tvalid  = (state == ST_DATA_OUT) && !fifo_empty;
    assign axis_tcp_src_tlast   = out_last;
    assign axis_tcp_src_tid     = 8'd0;
    assign tcp_tx_stat_data     = stat_q;
    assign tcp_notify_data      = notify_q;
    assign tcp_rx_meta_data     = lat_sid;

    tcp_lb_fifo #(
        .WIDTH (DATA_BITS + KEEP_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (sink_hs),
        .wr_data  ({axis_tcp_sink_tdata, wr_keep}),
        .rd_en    (src_hs),
        .rd_data  ({axis_tcp_src_tdata, axis_tcp_src_tkeep}),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (free_cnt)
    );

    always_comb begin
        err_event = 1'b0;
        if (state == ST_IDLE && tx_hs && len_bad) begin
            err_event = 1'b1;
        end
        if (state == ST_DATA_IN && sink_hs && (axis_tcp_sink_tlast != in_last)) begin
            err_event = 1'b1;
        end
        if (state == ST_WAIT_RD && rd_hs && !rd_match) begin
            err_event = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt <= '0;
        end else if (err_event && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= ST_IDLE;
            tcp_tx_meta_ready <= 1'b0;
            tcp_tx_stat_valid <= 1'b0;
            tcp_notify_valid  <= 1'b0;
            tcp_rd_pkg_ready  <= 1'b0;
            tcp_rx_meta_valid <= 1'b0;
            stat_q            <= '0;
            notify_q          <= '0;
            lat_sid           <= '0;
            lat_len           <= '0;
            beats             <= '0;
            in_cnt            <= '0;
            out_cnt           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_hs) begin
                        tcp_tx_meta_ready <= 1'b0;
                        tcp_tx_stat_valid <= 1'b1;
                        lat_sid           <= meta.sid;
                        lat_len           <= meta.len;
                        beats             <= beats_n;
                        stat_q            <= '{err:   len_bad ? ERR_SIZE : 2'b00,
                                               space: space_bytes,
                                               len:   meta.len,
                                               sid:   meta.sid};
                        state             <= ST_STAT;
                    end else begin
                        tcp_tx_meta_ready <= 1'b1;
                    end
                end
                ST_STAT: begin
                    if (stat_hs) begin
                        tcp_tx_stat_valid <= 1'b0;
                        in_cnt            <= '0;
                        state             <= (stat_q.err != 2'b00) ? ST_IDLE : ST_DATA_IN;
                    end
                end
                ST_DATA_IN: begin
                    // Beat count, not tlast, decides where the payload ends.
                    if (sink_hs) begin
                        in_cnt <= in_cnt + 16'd1;
                        if (in_last) begin
                            tcp_notify_valid <= 1'b1;
                            notify_q         <= '{closed: 1'b0, port: LOOP_PORT, ip: LOOP_IP,
                                                  len: lat_len, sid: lat_sid};
                            state            <= ST_NOTIFY;
                        end
                    end
                end
                ST_NOTIFY: begin
                    if (notify_hs) begin
                        tcp_notify_valid <= 1'b0;
                        tcp_rd_pkg_ready <= 1'b1;
                        state            <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    // Mismatched requests are consumed and counted; ready stays up.
                    if (rd_hs && rd_match) begin
                        tcp_rd_pkg_ready  <= 1'b0;
                        tcp_rx_meta_valid <= 1'b1;
                        state             <= ST_RX_META;
                    end
                end
                ST_RX_META: begin
                    if (rx_meta_hs) begin
                        tcp_rx_meta_valid <= 1'b0;
                        out_cnt           <= '0;
                        state             <= ST_DATA_OUT;
                    end
                end
                ST_DATA_OUT: begin
                    if (src_hs) begin
                        out_cnt <= out_cnt + 16'd1;
                        if (out_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_loopback_responder.sv
// tb/tb_tcp_loopback_responder.sv - scoreboard bench for tcp_loopback_responder
module tb_tcp_loopback_responder;

    localparam int          TO       = 3000;
    localparam logic [31:0] L_IP     = 32'h0A000001;
    localparam logic [15:0] L_PORT   = 16'd5001;
    localparam logic [29:0] SPACE    = 30'd4096;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         tcp_tx_meta_valid = 1'b0;
    logic         tcp_tx_meta_ready;
    logic [31:0]  tcp_tx_meta_data = '0;
    logic         tcp_tx_stat_valid;
    logic         tcp_tx_stat_ready = 1'b0;
    logic [63:0]  tcp_tx_stat_data;
    logic [511:0] axis_tcp_sink_tdata = '0;
    logic         axis_tcp_sink_tlast = 1'b0;
    logic         axis_tcp_sink_tvalid = 1'b0;
    logic         axis_tcp_sink_tready;
    logic         tcp_notify_valid;
    logic         tcp_notify_ready = 1'b0;
    logic [80:0]  tcp_notify_data;
    logic         tcp_rd_pkg_valid = 1'b0;
    logic         tcp_rd_pkg_ready;
    logic [31:0]  tcp_rd_pkg_data = '0;
    logic         tcp_rx_meta_valid;
    logic         tcp_rx_meta_ready = 1'b0;
    logic [15:0]  tcp_rx_meta_data;
    logic [511:0] axis_tcp_src_tdata;
    logic [63:0]  axis_tcp_src_tkeep;
    logic         axis_tcp_src_tlast;
    logic [7:0]   axis_tcp_src_tid;
    logic         axis_tcp_src_tvalid;
    logic         axis_tcp_src_tready = 1'b0;
    logic [15:0]  err_cnt;

    int    n_checks = 0;
    int    n_errs   = 0;
    int    exp_err  = 0;
    int    rx_count = 0;
    bit    src_rand = 1'b0;
    bit    src_on   = 1'b0;
    beat_t sb[$];

    tcp_loopback_responder dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .tcp_tx_meta_valid    (tcp_tx_meta_valid),
        .tcp_tx_meta_ready    (tcp_tx_meta_ready),
        .tcp_tx_meta_data     (tcp_tx_meta_data),
        .tcp_tx_stat_valid    (tcp_tx_stat_valid),
        .tcp_tx_stat_ready    (tcp_tx_stat_ready),
        .tcp_tx_stat_data     (tcp_tx_stat_data),
        .axis_tcp_sink_tdata  (axis_tcp_sink_tdata),
        .axis_tcp_sink_tlast  (axis_tcp_sink_tlast),
        .axis_tcp_sink_tvalid (axis_tcp_sink_tvalid),
        .axis_tcp_sink_tready (axis_tcp_sink_tready),
        .tcp_notify_valid     (tcp_notify_valid),
        .tcp_notify_ready     (tcp_notify_ready),
        .tcp_notify_data      (tcp_notify_data),
        .tcp_rd_pkg_valid     (tcp_rd_pkg_valid),
        .tcp_rd_pkg_ready     (tcp_rd_pkg_ready),
        .tcp_rd_pkg_data      (tcp_rd_pkg_data),
        .tcp_rx_meta_valid    (tcp_rx_meta_valid),
        .tcp_rx_meta_ready    (tcp_rx_meta_ready),
        .tcp_rx_meta_data     (tcp_rx_meta_data),
        .axis_tcp_src_tdata   (axis_tcp_src_tdata),
        .axis_tcp_src_tkeep   (axis_tcp_src_tkeep),
        .axis_tcp_src_tlast   (axis_tcp_src_tlast),
        .axis_tcp_src_tid     (axis_tcp_src_tid),
        .axis_tcp_src_tvalid  (axis_tcp_src_tvalid),
        .axis_tcp_src_tready  (axis_tcp_src_tready),
        .err_cnt              (err_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Egress monitor: drives src tready, then compares any beat about to be accepted.
    always @(negedge aclk) begin
        axis_tcp_src_tready = src_rand ? (($urandom % 3) != 0) : src_on;
        if (aresetn && axis_tcp_src_tvalid && axis_tcp_src_tready) begin
            if (sb.size() == 0) begin
                check("rx_unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("rx_tdata", axis_tcp_src_tdata, e.d);
                check("rx_tkeep", axis_tcp_src_tkeep, e.k);
                check("rx_tlast", axis_tcp_src_tlast, e.l);
                check("rx_tid", axis_tcp_src_tid, 0);
            end
            rx_count++;
        end
    end

    function automatic logic [511:0] rand_beat();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // All handshake tasks start and end on a falling edge.
    task automatic do_tx_meta(input logic [15:0] sid, input logic [15:0] len);
        int n = 0;
        tcp_tx_meta_data  = {len, sid};
        tcp_tx_meta_valid = 1'b1;
        while (!tcp_tx_meta_ready) begin
            if (n >= TO) begin check("tx_meta_timeout", 0, 1); break; end
            @(negedge aclk); n++;
        end
        @(negedge aclk);
        tcp_tx_meta_valid = 1'b0;
        check("tx_stat_latency", tcp_tx_stat_valid, 1);
    endtask

    task automatic expect_stat(input logic [63:0] exp);
        int n = 0;
        tcp_tx_stat_ready = 1'b1;
        while (!tcp_tx_stat_valid) begin
            if (n >= TO) begin check("tx_stat_timeout", 0, 1); break; end
            @(negedge aclk); n++;
        end
        check("tx_stat_data", tcp_tx_stat_data, exp);
        @(negedge aclk);
        tcp_tx_stat_ready = 1'b0;
    endtask

    task automatic send_beats(input logic [15:0] len, input bit rnd, input int bad);
        int beats = (int'(len) + 63) / 64;
        int rem   = int'(len) % 64;
        for (int i = 0; i < beats; i++) begin
            beat_t b;
            int n = 0;
            if (rnd) repeat ($urandom % 3) @(negedge aclk);
            b.d = rand_beat();
            b.l = (i == beats - 1);
            b.k = '1;
            if (b.l && rem != 0) b.k = (64'h1 << rem) - 64'h1;
            axis_tcp_sink_tdata  = b.d;
            axis_tcp_sink_tlast  = b.l || (i == bad);
            axis_tcp_sink_tvalid = 1'b1;
            while (!axis_tcp_sink_tready) begin
                if (n >= TO) begin check("sink_timeout", 0, 1); break; end
                @(negedge aclk); n++;
            end
            sb.push_back(b);
            @(negedge aclk);
            axis_tcp_sink_tvalid = 1'b0;
        end
        axis_tcp_sink_tlast = 1'b0;
    endtask

    task automatic expect_notify(input logic [15:0] sid, input logic [15:0] len);
        int n = 0;
        tcp_notify_ready = 1'b1;
        while (!tcp_notify_valid) begin
            if (n >= TO) begin check("notify_timeout", 0, 1); break; end
            @(negedge aclk); n++;
        end
        check("notify_data", tcp_notify_data, {1'b0, L_PORT, L_IP, len, sid});
        @(negedge aclk);
        tcp_notify_ready = 1'b0;
    endtask

    task automatic do_rd_pkg(input logic [15:0] sid, input logic [15:0] len);
        int n = 0;
        tcp_rd_pkg_data  = {len, sid};
        tcp_rd_pkg_valid = 1'b1;
        while (!tcp_rd_pkg_ready) begin
            if (n >= TO) begin check("rd_pkg_timeout", 0, 1); break; end
            @(negedge aclk); n++;
        end
        @(negedge aclk);
        tcp_rd_pkg_valid = 1'b0;
    endtask

    task automatic expect_rx_meta(input logic [15:0] sid);
        int n = 0;
        tcp_rx_meta_ready = 1'b1;
        while (!tcp_rx_meta_valid) begin
            if (n >= TO) begin check("rx_meta_timeout", 0, 1); break; end
            @(negedge aclk); n++;
        end
        check("rx_meta_data", tcp_rx_meta_data, sid);
        check("rx_before_meta", axis_tcp_src_tvalid, 0);
        @(negedge aclk);
        tcp_rx_meta_ready = 1'b0;
    endtask

    task automatic ingress(input logic [15:0] sid, input logic [15:0] len,
                           input bit rnd, input int bad);
        int beats = (int'(len) + 63) / 64;
        do_tx_meta(sid, len);
        expect_stat({2'b00, SPACE, len, sid});
        send_beats(len, rnd, bad);
        if (bad >= 0 && bad != beats - 1) exp_err++;
        expect_notify(sid, len);
    endtask

    task automatic egress(input logic [15:0] len, input bit rnd);
        int beats = (int'(len) + 63) / 64;
        int n = 0;
        rx_count = 0;
        src_rand = rnd;
        src_on   = 1'b1;
        while (rx_count < beats) begin
            if (n >= TO) begin check("egress_timeout", 0, 1); break; end
            @(negedge aclk); n++;
        end
        @(negedge aclk);
        @(negedge aclk);
        src_rand = 1'b0;
        src_on   = 1'b0;
        check("rx_beat_count", rx_count, beats);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic full_xfer(input logic [15:0] sid, input logic [15:0] len,
                             input bit rnd, input int bad);
        ingress(sid, len, rnd, bad);
        do_rd_pkg(sid, len);
        expect_rx_meta(sid);
        egress(len, rnd);
        check("err_cnt_after_xfer", err_cnt, exp_err);
    endtask

    task automatic bad_len(input logic [15:0] sid, input logic [15:0] len);
        do_tx_meta(sid, len);
        expect_stat({2'b01, SPACE, len, sid});
        exp_err++;
        repeat (3) begin
            check("sink_tready_after_err", axis_tcp_sink_tready, 0);
            @(negedge aclk);
        end
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        check("rst_tx_meta_ready", tcp_tx_meta_ready, 0);
        check("rst_tx_stat_valid", tcp_tx_stat_valid, 0);
        check("rst_notify_valid", tcp_notify_valid, 0);
        check("rst_rd_pkg_ready", tcp_rd_pkg_ready, 0);
        check("rst_rx_meta_valid", tcp_rx_meta_valid, 0);
        check("rst_src_tvalid", axis_tcp_src_tvalid, 0);
        check("rst_sink_tready", axis_tcp_sink_tready, 0);
        check("rst_err_cnt", err_cnt, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Case 1 and 2: aligned and partial last beat.
        full_xfer(16'd3, 16'd128, 1'b0, -1);
        full_xfer(16'd9, 16'd100, 1'b0, -1);

        // Case 3: zero and oversize lengths are rejected.
        bad_len(16'd5, 16'd0);
        bad_len(16'd6, 16'd4097);
        check("err_cnt_bad_len", err_cnt, 2);

        // Case 4: mismatched read request is consumed and counted.
        ingress(16'd3, 16'd128, 1'b0, -1);
        do_rd_pkg(16'd4, 16'd128);
        exp_err++;
        repeat (3) begin
            check("no_rx_meta_on_mismatch", tcp_rx_meta_valid, 0);
            @(negedge aclk);
        end
        check("err_cnt_rd_mismatch", err_cnt, exp_err);
        do_rd_pkg(16'd3, 16'd128);
        expect_rx_meta(16'd3);
        egress(16'd128, 1'b0);

        // Early tlast: counted, payload still delivered.
        full_xfer(16'd11, 16'd128, 1'b0, 0);

        // Case 5: random backpressure, including a transfer that fills the FIFO.
        full_xfer(16'd20, 16'd2048, 1'b1, -1);
        full_xfer(16'd21, 16'd2047, 1'b1, -1);
        full_xfer(16'd22, 16'd4096, 1'b1, -1);

        // Case 6: reset in the middle of egress.
        ingress(16'd7, 16'd2048, 1'b0, -1);
        do_rd_pkg(16'd7, 16'd2048);
        expect_rx_meta(16'd7);
        rx_count = 0;
        src_rand = 1'b1;
        begin
            int n = 0;
            while (rx_count < 5) begin
                if (n >= TO) begin check("pre_reset_timeout", 0, 1); break; end
                @(negedge aclk); n++;
            end
        end
        #2 aresetn = 1'b0;
        #1;
        check("midrst_src_tvalid", axis_tcp_src_tvalid, 0);
        check("midrst_tx_stat_valid", tcp_tx_stat_valid, 0);
        check("midrst_notify_valid", tcp_notify_valid, 0);
        check("midrst_rx_meta_valid", tcp_rx_meta_valid, 0);
        check("midrst_rd_pkg_ready", tcp_rd_pkg_ready, 0);
        check("midrst_err_cnt", err_cnt, 0);
        src_rand = 1'b0;
        sb.delete();
        exp_err = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        full_xfer(16'd3, 16'd128, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
